// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO controller in front of a single-clock dual-port RAM
// with a registered (1-cycle) read port and no read enable.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          synchronous clear of pointers, count and rd_valid
//   wr_en/wr_data  push request and data
//   rd_en          pop request
//   rd_data        popped word (RAM q), qualified by rd_valid
//   full/empty     occupancy flags, count = occupancy
//   ovf/udf        sticky push-while-full / pop-while-empty, cleared by clr_err
//   ram_we, ram_w_addr, ram_d   RAM write port
//   ram_r_addr, ram_q           RAM read port
//
// Optional: define DPRAM_FIFO_CTRL_ALMOST_EN to add registered almost_full /
// almost_empty outputs derived from the next-state count.

module dpram_fifo_ctrl #(
    parameter int Data_width = 8,
    parameter int Addr_width = 10,
    parameter int AF_level   = 2**Addr_width-4,
    parameter int AE_level   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [Data_width-1:0] wr_data,
    input  logic                  rd_en,
    output logic [Data_width-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic [Addr_width:0]   count,
    output logic                  ovf,
    output logic                  udf,
    input  logic                  clr_err,
`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
    output logic                  almost_full,
    output logic                  almost_empty,
`endif
    output logic                  ram_we,
    output logic [Addr_width-1:0] ram_w_addr,
    output logic [Addr_width-1:0] ram_r_addr,
    output logic [Data_width-1:0] ram_d,
    input  logic [Data_width-1:0] ram_q
);

    localparam logic [Addr_width:0] DEPTH =
        {1'b1, {Addr_width{1'b0}}};
    localparam logic [Addr_width:0] CNT_ONE =
        {{Addr_width{1'b0}}, 1'b1};
    localparam logic [Addr_width-1:0] PTR_ONE =
        {{(Addr_width-1){1'b0}}, 1'b1};

    // Thresholds outside the count range would make the almost flags
    // meaningless; reject such builds at elaboration.
    if (AE_level < 0 || AF_level < 0 ||
        AE_level > 2**Addr_width || AF_level > 2**Addr_width) begin : g_bad_lvl
        $error("dpram_fifo_ctrl: AF_level/AE_level outside 0..DEPTH");
    end

    logic [Addr_width-1:0] r_wptr;
    logic [Addr_width-1:0] r_rptr;
    logic [Addr_width:0]   r_count;
    logic                  r_rd_valid;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [Addr_width:0]   w_count_nxt;

    // Acceptance uses the flags as they stand at the start of the cycle;
    // flush overrides both sides.
    assign w_full    = (r_count == DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = wr_en & ~w_full & ~flush;
    assign w_pop_ok  = rd_en & ~w_empty & ~flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else begin
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   w_count_nxt = r_count + CNT_ONE;
                2'b01:   w_count_nxt = r_count - CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_rd_valid <= w_pop_ok;
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
                if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // A new error in the same cycle as clr_err wins, so the flag stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wr_en && w_full)  r_ovf <= 1'b1;
            else if (clr_err)     r_ovf <= 1'b0;
            if (rd_en && w_empty) r_udf <= 1'b1;
            else if (clr_err)     r_udf <= 1'b0;
        end
    end

`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
    localparam logic [Addr_width:0] AF_L = (Addr_width+1)'(AF_level);
    localparam logic [Addr_width:0] AE_L = (Addr_width+1)'(AE_level);

    logic r_almost_full;
    logic r_almost_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= AF_L);
            r_almost_empty <= (w_count_nxt <= AE_L);
        end
    end

    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
`endif

    // The RAM registers mem[rptr] every edge, so the word for a pop
    // accepted at edge N is on ram_q during cycle N+1, matching rd_valid.
    assign ram_we     = w_push_ok;
    assign ram_w_addr = r_wptr;
    assign ram_d      = wr_data;
    assign ram_r_addr = r_rptr;

    assign rd_data  = ram_q;
    assign rd_valid = r_rd_valid;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign ovf      = r_ovf;
    assign udf      = r_udf;

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences the team's single-clock dual-port RAM (registered read, 1-cycle read latency, no read enable) into a first-in-first-out buffer.
- Owns the write/read pointers, occupancy count, status flags and error flags; drives the RAM write port and read address, and returns the RAM's registered read data with a valid strobe.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- Data_width, 8, bits per word; must match the attached RAM.
- Addr_width, 10, RAM address bits; depth DEPTH = 2**Addr_width.
- AF_level, 2**Addr_width-4, almost-full threshold in words (optional feature only).
- AE_level, 4, almost-empty threshold in words (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO state.
- wr_en  in  1  push request.
- wr_data  in  Data_width  push data.
- rd_en  in  1  pop request.
- rd_data  out  Data_width  popped word; equals ram_q.
- rd_valid  out  1  rd_data holds a popped word this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  Addr_width+1  current occupancy.
- ovf  out  1  sticky: push attempted while full.
- udf  out  1  sticky: pop attempted while empty.
- clr_err  in  1  synchronous clear of ovf/udf.
- ram_we  out  1  RAM write enable.
- ram_w_addr  out  Addr_width  RAM write address.
- ram_r_addr  out  Addr_width  RAM read address.
- ram_d  out  Data_width  RAM write data.
- ram_q  in  Data_width  RAM registered read data.

Behaviour:
- Reset: asynchronous, on rst_n low. Sets wptr=0, rptr=0, count=0, rd_valid=0, ovf=0, udf=0. Flags follow as empty=1, full=0. RAM contents are not reset; the controller never exposes unwritten words.
- Acceptance is evaluated on flag state at the start of the cycle:
  - push_ok = wr_en & !full
  - pop_ok = rd_en & !empty
- Write port (combinational):
  - ram_we = push_ok
  - ram_w_addr = wptr
  - ram_d = wr_data
  - wptr increments on push_ok.
- Read path:
  - ram_r_addr = rptr (combinational), so the RAM registers the word at rptr on every edge.
  - rptr increments on pop_ok.
  - rd_valid is a register loaded with pop_ok. rd_data = ram_q.
  - Pop latency is exactly 1 cycle: a pop accepted at edge N presents its word with rd_valid=1 during cycle N+1.
- Pointers are Addr_width bits and wrap from DEPTH-1 to 0 naturally.
- Count update:
  - +1 on push_ok only
  - -1 on pop_ok only
  - unchanged when both or neither
- Full and simultaneous push+pop: only the pop is accepted; count becomes DEPTH-1 and ovf sets.
- Empty and simultaneous push+pop: only the push is accepted; count becomes 1 and udf sets. The new word can be popped the next cycle; the RAM write completes at the same edge the count updates.
- Non-full, non-empty and simultaneous push+pop: both are accepted and count holds.
- Error flags: ovf sets on wr_en & full; udf sets on rd_en & empty. Both hold until clr_err or reset. If clr_err and a new error occur in the same cycle, the flag ends set.
- flush: highest synchronous priority.
  - Sets wptr=rptr=0, count=0, rd_valid=0.
  - Suppresses ram_we and pop acceptance that cycle.
  - Does not touch ovf/udf.
- Reset mid-operation: all state clears immediately. rd_valid drops asynchronously, and any in-flight pop data is discarded.

Optional Feature:
- Macro: DPRAM_FIFO_CTRL_ALMOST_EN
- Defined: adds registered outputs almost_full (1 bit) and almost_empty (1 bit), both computed from the next-state count.
  - almost_full = next_count >= AF_level
  - almost_empty = next_count <= AE_level
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: these ports and their logic do not exist; AF_level and AE_level are unused.

Test Plan:
- Reset then idle, Addr_width=4 -> empty=1, full=0, count=0, rd_valid=0, ovf=udf=0, ram_we=0.
- Push 0x11,0x22,0x33, then pop 3 back-to-back -> rd_valid high for 3 cycles starting 1 cycle after the first pop, rd_data 0x11,0x22,0x33, count ends 0, empty=1.
- Fill 16 words (Addr_width=4), then push 0xAA -> full=1, count=16, ram_we=0 on the 17th push, ovf=1. Then pop 16 -> original order returned, 0xAA never appears.
- Continuous push+pop for 40 cycles at count=5 -> count stays 5, data order preserved across pointer wrap 15->0.
- Pop while empty with push 0x5C in the same cycle -> udf=1, count=1, pop next cycle returns 0x5C. clr_err -> udf=0.
- Assert rst_n low mid-burst with count=7 -> count=0, empty=1, rd_valid=0 without waiting for a clock edge. flush at count=9 -> count=0 next edge, ovf/udf unchanged.
